// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind the UART receiver: FWFT valid/ready read port, sticky overrun.
// Define UART_RX_FIFO_OVERWRITE_EN to overwrite the oldest byte when full instead of dropping.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_tick,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ready,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overrun,
    input  logic                  overrun_clr
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

`ifdef UART_RX_FIFO_OVERWRITE_EN
    localparam bit OVERWRITE = 1'b1;
`else
    localparam bit OVERWRITE = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    logic push;
    logic pop;
    logic push_full;
    logic do_write;
    logic rd_adv;

    assign empty    = (count == '0);
    assign full     = (count == CNT_FULL);
    assign rd_valid = !empty;
    assign rd_data  = mem[rd_ptr];

    assign push      = wr_tick;
    assign pop       = rd_valid && rd_ready;
    // A push while full is only an overrun when no pop frees a slot that cycle
    assign push_full = push && full && !pop;
    assign do_write  = push && (!push_full || OVERWRITE);
    assign rd_adv    = pop || (push_full && OVERWRITE);

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (push && !pop && !full) begin
            count <= count + CNT_ONE;
        end else if (pop && !push) begin
            count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (push_full) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a byte scoreboard queue.
// Expected bytes are queued on every write and compared on every read.
module tb_uart_rx_fifo;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_tick;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ready;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overrun;
    logic          overrun_clr;

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] q[$];
    logic ovr_m = 1'b0;

    uart_rx_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .reset(reset),
        .wr_tick(wr_tick),
        .wr_data(wr_data),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .rd_ready(rd_ready),
        .full(full),
        .empty(empty),
        .count(count),
        .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [DW-1:0] b, input logic clr);
        wr_tick = 1'b1;
        wr_data = b;
        overrun_clr = clr;
        rd_ready = 1'b0;
        if (q.size() < DEPTH) begin
            q.push_back(b);
            if (clr) ovr_m = 1'b0;
        end else begin
            ovr_m = 1'b1;
`ifdef UART_RX_FIFO_OVERWRITE_EN
            void'(q.pop_front());
            q.push_back(b);
`endif
        end
        tick();
        wr_tick = 1'b0;
        overrun_clr = 1'b0;
    endtask

    task automatic read_check(input string tag);
        logic [DW-1:0] e;
        check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s_sb observed=read expected=empty_scoreboard", tag);
        end else begin
            e = q.pop_front();
            check({tag, "_data"}, {24'd0, rd_data}, {24'd0, e});
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic push_pop(input logic [DW-1:0] b, input string tag);
        logic [DW-1:0] e;
        check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        e = q.pop_front();
        check({tag, "_data"}, {24'd0, rd_data}, {24'd0, e});
        q.push_back(b);
        wr_tick = 1'b1;
        wr_data = b;
        rd_ready = 1'b1;
        tick();
        wr_tick = 1'b0;
        rd_ready = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, {27'd0, count}, q.size());
        check({tag, "_empty"}, {31'd0, empty}, {31'd0, q.size() == 0});
        check({tag, "_full"}, {31'd0, full}, {31'd0, q.size() == DEPTH});
        check({tag, "_ovr"}, {31'd0, overrun}, {31'd0, ovr_m});
    endtask

    task automatic drain(input string tag);
        while (q.size() > 0) read_check(tag);
        check_state({tag, "_end"});
    endtask

    initial begin
        reset = 1'b1;
        wr_tick = 1'b0;
        wr_data = '0;
        rd_ready = 1'b0;
        overrun_clr = 1'b0;
        tick();
        tick();
        check_state("reset");
        check("reset_valid", {31'd0, rd_valid}, 32'd0);
        reset = 1'b0;
        tick();

        write_byte(8'h7E, 1'b0);
        check_state("single");
        read_check("single");
        check_state("single_pop");

        for (int i = 0; i < DEPTH; i++) write_byte(8'(i), 1'b0);
        check_state("fill");
        drain("fill");

        for (int i = 0; i < DEPTH; i++) write_byte(8'(i), 1'b0);
        write_byte(8'hAA, 1'b0);
        check_state("ovr");
        drain("ovr");

        for (int i = 0; i < DEPTH; i++) write_byte(8'(16 + i), 1'b0);
        write_byte(8'hBB, 1'b1);
        check_state("ovr_clr_set");
        overrun_clr = 1'b1;
        ovr_m = 1'b0;
        tick();
        overrun_clr = 1'b0;
        check_state("ovr_clr");

        push_pop(8'h55, "pp");
        check_state("pp");
        drain("pp");

        for (int i = 0; i < 4; i++) begin
            logic [31:0] pat;
            pat = 32'h7E8100FF;
            write_byte(pat[31 - 8*i -: 8], 1'b0);
            repeat (9) tick();
            read_check("loop");
        end
        check_state("loop");

        write_byte(8'h11, 1'b0);
        write_byte(8'h22, 1'b0);
        #2;
        reset = 1'b1;
        wr_tick = 1'b1;
        wr_data = 8'h99;
        #1;
        q.delete();
        ovr_m = 1'b0;
        check("rst_mid_count", {27'd0, count}, 32'd0);
        check("rst_mid_valid", {31'd0, rd_valid}, 32'd0);
        tick();
        reset = 1'b0;
        wr_tick = 1'b0;
        tick();
        check_state("rst_release");
        check("rst_release_valid", {31'd0, rd_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
